// File: rtl/sd_sector_loader_pkg.sv
// sd_sector_loader_pkg: shared codes, constants and state encodings for the SD sector loader.
// Rev 1.0
`default_nettype none

package sd_sector_loader_pkg;

  localparam logic [1:0] SD_INIT   = 2'd0;
  localparam logic [1:0] SD_TRX    = 2'd1;
  localparam logic [1:0] SD_CS_EN  = 2'd2;
  localparam logic [1:0] SD_CS_DIS = 2'd3;

  localparam logic [7:0] CMD17_OP   = 8'h51;
  localparam logic [7:0] DUMMY_CRC  = 8'h01;
  localparam logic [7:0] DATA_TOKEN = 8'hFE;
  localparam logic [7:0] FILL_BYTE  = 8'hFF;

  localparam logic [2:0] ERR_OK    = 3'd0;
  localparam logic [2:0] ERR_R1    = 3'd1;
  localparam logic [2:0] ERR_R1_TO = 3'd2;
  localparam logic [2:0] ERR_TOKEN = 3'd3;
  localparam logic [2:0] ERR_HS    = 3'd4;

  localparam int SECTOR_BYTES = 512;

  typedef enum logic [1:0] {
    XS_IDLE    = 2'd0,
    XS_WAIT_HI = 2'd1,
    XS_WAIT_LO = 2'd2
  } xfer_state_t;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_PRE_DIS = 4'd1,
    ST_PRE_FF  = 4'd2,
    ST_CS_ON   = 4'd3,
    ST_CMD     = 4'd4,
    ST_R1      = 4'd5,
    ST_TOKEN   = 4'd6,
    ST_DATA    = 4'd7,
    ST_CRC     = 4'd8,
    ST_CS_OFF  = 4'd9,
    ST_NEXT    = 4'd10,
    ST_FAIL    = 4'd11,
    ST_DONE    = 4'd12
  } loader_state_t;

  // Byte idx of the six-byte CMD17 frame (block addressing, fixed dummy CRC).
  function automatic logic [7:0] cmd17_byte(input logic [2:0] idx, input logic [31:0] lba);
    logic [7:0] b;
    case (idx)
      3'd0:    b = CMD17_OP;
      3'd1:    b = lba[31:24];
      3'd2:    b = lba[23:16];
      3'd3:    b = lba[15:8];
      3'd4:    b = lba[7:0];
      default: b = DUMMY_CRC;
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sd_sector_loader_xfer.sv
// sd_byte_xfer: one strobe/busy-edge handshake with the SPI SD controller, with timeout.
// Rev 1.0
`default_nettype none

module sd_byte_xfer
  import sd_sector_loader_pkg::*;
#(
  parameter int HS_TIMEOUT = 1023
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_req,
  input  logic [1:0] i_cmd,
  input  logic [7:0] i_byte,
  output logic       o_ack,
  output logic [7:0] o_rx,
  output logic       o_timeout,
  output logic [1:0] sd_cmd,
  output logic [7:0] sd_out,
  output logic       sd_signal,
  input  logic [7:0] sd_din,
  input  logic       sd_busy,
  input  logic       sd_timeout
);

  localparam int CW = $clog2(HS_TIMEOUT + 1);

  xfer_state_t   r_state;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= XS_IDLE;
      r_cnt     <= '0;
      o_ack     <= 1'b0;
      o_rx      <= 8'h00;
      o_timeout <= 1'b0;
      sd_cmd    <= 2'd0;
      sd_out    <= 8'h00;
      sd_signal <= 1'b0;
    end else begin
      sd_signal <= 1'b0;
      o_ack     <= 1'b0;
      case (r_state)
        XS_IDLE: begin
          if (i_req) begin
            sd_cmd    <= i_cmd;
            sd_out    <= i_byte;
            sd_signal <= 1'b1;
            r_cnt     <= '0;
            o_timeout <= 1'b0;
            r_state   <= XS_WAIT_HI;
          end
        end
        XS_WAIT_HI, XS_WAIT_LO: begin
          // A controller timeout or an exhausted cycle budget both end the byte early.
          if (sd_timeout || r_cnt == CW'(HS_TIMEOUT - 1)) begin
            o_ack     <= 1'b1;
            o_timeout <= 1'b1;
            r_state   <= XS_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_state == XS_WAIT_HI && sd_busy) begin
              r_state <= XS_WAIT_LO;
            end else if (r_state == XS_WAIT_LO && !sd_busy) begin
              o_rx    <= sd_din;
              o_ack   <= 1'b1;
              r_state <= XS_IDLE;
            end
          end
        end
        default: r_state <= XS_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sd_sector_loader.sv
// sd_sector_loader: reads 512-byte sectors with CMD17 and streams them into the tape store.
// Rev 1.0
`default_nettype none

module sd_sector_loader
  import sd_sector_loader_pkg::*;
#(
  parameter int R1_TRIES    = 8,
  parameter int TOKEN_TRIES = 4096,
  parameter int HS_TIMEOUT  = 1023
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] lba,
  input  logic [7:0]  count,
  input  logic [16:0] dst,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err,
  output logic [1:0]  sd_cmd,
  output logic [7:0]  sd_out,
  output logic        sd_signal,
  input  logic [7:0]  sd_din,
  input  logic        sd_busy,
  input  logic        sd_timeout,
  output logic [16:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_we
);

  loader_state_t r_state;
  logic [31:0]   r_lba;
  logic [7:0]    r_count;
  logic [16:0]   r_addr;
  logic [9:0]    r_idx;
  logic [15:0]   r_tries;
  logic          r_wait;
  logic          r_req;

  logic          w_ack;
  logic [7:0]    w_rx;
  logic          w_to;
  logic          w_xfer_state;
  logic [1:0]    w_xcmd;
  logic [7:0]    w_xbyte;

  // Every state except IDLE/NEXT/DONE moves exactly one byte or CS command per visit.
  always_comb begin
    w_xfer_state = 1'b1;
    w_xcmd       = SD_TRX;
    w_xbyte      = FILL_BYTE;
    case (r_state)
      ST_PRE_DIS, ST_CS_OFF, ST_FAIL: w_xcmd = SD_CS_DIS;
      ST_CS_ON:                       w_xcmd = SD_CS_EN;
      ST_CMD:                         w_xbyte = cmd17_byte(r_idx[2:0], r_lba);
      ST_IDLE, ST_NEXT, ST_DONE:      w_xfer_state = 1'b0;
      default:                        w_xfer_state = 1'b1;
    endcase
  end

  sd_byte_xfer #(
    .HS_TIMEOUT (HS_TIMEOUT)
  ) u_xfer (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_req      (r_req),
    .i_cmd      (w_xcmd),
    .i_byte     (w_xbyte),
    .o_ack      (w_ack),
    .o_rx       (w_rx),
    .o_timeout  (w_to),
    .sd_cmd     (sd_cmd),
    .sd_out     (sd_out),
    .sd_signal  (sd_signal),
    .sd_din     (sd_din),
    .sd_busy    (sd_busy),
    .sd_timeout (sd_timeout)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_lba    <= 32'h0;
      r_count  <= 8'h0;
      r_addr   <= 17'h0;
      r_idx    <= 10'h0;
      r_tries  <= 16'h0;
      r_wait   <= 1'b0;
      r_req    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= ERR_OK;
      mem_addr <= 17'h0;
      mem_data <= 8'h0;
      mem_we   <= 1'b0;
    end else begin
      done   <= 1'b0;
      mem_we <= 1'b0;
      r_req  <= 1'b0;
      if (w_xfer_state && !r_wait) begin
        r_req  <= 1'b1;
        r_wait <= 1'b1;
      end
      if (w_ack) r_wait <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            err <= ERR_OK;
            if (count == 8'd0) begin
              done <= 1'b1;
            end else begin
              r_lba   <= lba;
              r_count <= count;
              r_addr  <= dst;
              r_idx   <= 10'd0;
              r_tries <= 16'd0;
              busy    <= 1'b1;
              r_state <= ST_PRE_DIS;
            end
          end
        end
        ST_NEXT: begin
          r_count <= r_count - 8'd1;
          r_lba   <= r_lba + 32'd1;
          r_state <= (r_count == 8'd1) ? ST_DONE : ST_CS_ON;
        end
        ST_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          if (w_ack) begin
            // A handshake timeout during the closing CS disable keeps the original error.
            if (w_to && r_state != ST_FAIL) begin
              err     <= ERR_HS;
              r_state <= ST_FAIL;
            end else begin
              case (r_state)
                ST_PRE_DIS: r_state <= ST_PRE_FF;
                ST_PRE_FF:  r_state <= ST_CS_ON;
                ST_CS_ON: begin
                  r_idx   <= 10'd0;
                  r_state <= ST_CMD;
                end
                ST_CMD: begin
                  if (r_idx == 10'd5) begin
                    r_idx   <= 10'd0;
                    r_tries <= 16'd0;
                    r_state <= ST_R1;
                  end else begin
                    r_idx <= r_idx + 10'd1;
                  end
                end
                ST_R1: begin
                  if (w_rx == 8'h00) begin
                    r_tries <= 16'd0;
                    r_state <= ST_TOKEN;
                  end else if (w_rx != FILL_BYTE) begin
                    err     <= ERR_R1;
                    r_state <= ST_FAIL;
                  end else if (r_tries == 16'(R1_TRIES - 1)) begin
                    err     <= ERR_R1_TO;
                    r_state <= ST_FAIL;
                  end else begin
                    r_tries <= r_tries + 16'd1;
                  end
                end
                ST_TOKEN: begin
                  if (w_rx == DATA_TOKEN) begin
                    r_idx   <= 10'd0;
                    r_state <= ST_DATA;
                  end else if (w_rx != FILL_BYTE || r_tries == 16'(TOKEN_TRIES - 1)) begin
                    err     <= ERR_TOKEN;
                    r_state <= ST_FAIL;
                  end else begin
                    r_tries <= r_tries + 16'd1;
                  end
                end
                ST_DATA: begin
                  mem_we   <= 1'b1;
                  mem_addr <= r_addr;
                  mem_data <= w_rx;
                  r_addr   <= r_addr + 17'd1;
                  if (r_idx == 10'(SECTOR_BYTES - 1)) begin
                    r_idx   <= 10'd0;
                    r_state <= ST_CRC;
                  end else begin
                    r_idx <= r_idx + 10'd1;
                  end
                end
                ST_CRC: begin
                  if (r_idx == 10'd1) begin
                    r_idx   <= 10'd0;
                    r_state <= ST_CS_OFF;
                  end else begin
                    r_idx <= r_idx + 10'd1;
                  end
                end
                ST_CS_OFF: r_state <= ST_NEXT;
                ST_FAIL:   r_state <= ST_DONE;
                default:   r_state <= ST_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sd_sector_loader.sv
// tb_sd_sector_loader: directed bench with an SD card/controller bus model.
// Rev 1.0
`default_nettype none

module tb_sd_sector_loader;
  import sd_sector_loader_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] lba = 32'h0;
  logic [7:0]  count = 8'h0;
  logic [16:0] dst = 17'h0;
  logic        busy, done, sd_signal, mem_we;
  logic [2:0]  err;
  logic [1:0]  sd_cmd;
  logic [7:0]  sd_out, mem_data;
  logic [16:0] mem_addr;
  logic [7:0]  sd_din = 8'h00;
  logic        sd_busy = 1'b0;
  logic        sd_timeout = 1'b0;

  always #5 clock = ~clock;

  sd_sector_loader dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .lba        (lba),
    .count      (count),
    .dst        (dst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .sd_cmd     (sd_cmd),
    .sd_out     (sd_out),
    .sd_signal  (sd_signal),
    .sd_din     (sd_din),
    .sd_busy    (sd_busy),
    .sd_timeout (sd_timeout),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus model configuration and observations.
  logic [7:0]  r1_resp, tok_resp, pending;
  logic        stuck, to_en;
  int          bcnt, k, sess, ev_n, viol, done_n, wr_n, wr_bad;
  logic [2:0]  done_err;
  logic [16:0] wr_base;
  logic [1:0]  last_cmd;
  logic [1:0]  ev_cmd [0:2];
  logic [7:0]  ev_byte[0:2];
  logic [7:0]  cmdb   [0:1][0:5];
  int          sess_trx[0:1];

  task automatic model_clear(input logic [7:0] r1, input logic [7:0] tok, input logic [16:0] base);
    r1_resp = r1; tok_resp = tok; wr_base = base;
    stuck = 1'b0; to_en = 1'b0;
    bcnt = 0; k = 0; sess = -1; ev_n = 0; viol = 0; done_n = 0; wr_n = 0; wr_bad = 0;
    done_err = 3'd7; last_cmd = SD_INIT; pending = 8'hFF;
    sd_busy = 1'b0; sd_timeout = 1'b0; sd_din = 8'h00;
    for (int s = 0; s < 2; s++) begin
      sess_trx[s] = 0;
      for (int j = 0; j < 6; j++) cmdb[s][j] = 8'h00;
    end
    for (int j = 0; j < 3; j++) begin ev_cmd[j] = SD_INIT; ev_byte[j] = 8'h00; end
  endtask

  function automatic logic [7:0] card_resp(input int kk);
    int p;
    p = kk - 6;
    if (kk < 6)                        return 8'hFF;
    if (p == 0)                        return r1_resp;
    if (r1_resp != 8'h00)              return r1_resp;
    if (p == 1 || tok_resp != 8'hFE)   return tok_resp;
    if (p - 2 < 512)                   return 8'(p - 2);
    return 8'hA5;
  endfunction

  always @(negedge clock) begin
    if (sd_signal && (sd_busy || bcnt > 0)) viol++;
    sd_timeout = 1'b0;
    if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) begin sd_busy = 1'b0; sd_din = pending; end
    end
    if (sd_signal) begin
      if (ev_n < 3) begin ev_cmd[ev_n] = sd_cmd; ev_byte[ev_n] = sd_out; end
      ev_n++;
      last_cmd = sd_cmd;
      pending  = 8'hFF;
      if (sd_cmd == SD_CS_EN) begin k = 0; sess++; end
      if (sd_cmd == SD_TRX && sess >= 0) begin
        if (sess < 2) begin
          if (k < 6) cmdb[sess][k] = sd_out;
          sess_trx[sess]++;
        end
        pending = card_resp(k);
        k++;
      end
      if (to_en && sd_cmd == SD_TRX && sess == 0 && k == 3) begin
        sd_timeout = 1'b1;
      end else begin
        sd_busy = 1'b1;
        bcnt    = stuck ? 0 : 4;
      end
    end
    if (mem_we) begin
      if (mem_addr !== wr_base + 17'(wr_n) || mem_data !== 8'(wr_n)) wr_bad++;
      wr_n++;
    end
    if (done) begin done_n++; done_err = err; end
  end

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; start = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic pulse_start(input logic [31:0] l, input logic [7:0] c, input logic [16:0] d);
    @(negedge clock);
    start = 1'b1; lba = l; count = c; dst = d;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_n == 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(tag, 64'(done_n != 0), 64'd1);
    repeat (3) @(negedge clock);
  endtask

  initial begin
    model_clear(8'h00, 8'hFE, 17'h01000);
    @(negedge clock);
    @(negedge clock);
    check("reset_outs", {busy, done, err, sd_cmd, sd_out, sd_signal, mem_addr, mem_data, mem_we}, 64'd0);
    reset_n = 1'b1;

    // Single sector, plus a start while busy that must be ignored.
    pulse_start(32'h00000010, 8'd1, 17'h01000);
    check("busy_after_start", 64'(busy), 64'd1);
    pulse_start(32'hDEADBEEF, 8'd5, 17'h00000);
    wait_done("t1_done", 20000);
    check("t1_err", 64'(done_err), 64'(ERR_OK));
    check("t1_done_cnt", 64'(done_n), 64'd1);
    check("t1_cmd", {cmdb[0][0], cmdb[0][1], cmdb[0][2], cmdb[0][3], cmdb[0][4], cmdb[0][5]}, 64'h510000001001);
    check("t1_writes", 64'(wr_n), 64'd512);
    check("t1_wr_bad", 64'(wr_bad), 64'd0);
    check("t1_pre", {ev_cmd[0], ev_byte[0], ev_cmd[1], ev_byte[1], ev_cmd[2]}, {SD_CS_DIS, 8'hFF, SD_TRX, 8'hFF, SD_CS_EN});
    check("t1_last_cs", 64'(last_cmd), 64'(SD_CS_DIS));
    check("t1_sessions", 64'(sess), 64'd0);
    check("t1_busy_low", 64'(busy), 64'd0);
    check("t1_viol", 64'(viol), 64'd0);

    // Two sectors with tape-address wrap.
    do_reset(); model_clear(8'h00, 8'hFE, 17'h1FF00);
    pulse_start(32'h12345678, 8'd2, 17'h1FF00);
    wait_done("t2_done", 40000);
    check("t2_err", 64'(done_err), 64'(ERR_OK));
    check("t2_cmd2", {cmdb[1][0], cmdb[1][1], cmdb[1][2], cmdb[1][3], cmdb[1][4], cmdb[1][5]}, 64'h511234567901);
    check("t2_writes", 64'(wr_n), 64'd1024);
    check("t2_wr_bad", 64'(wr_bad), 64'd0);
    check("t2_last_addr", 64'(mem_addr), 64'h002FF);

    // Bad R1.
    do_reset(); model_clear(8'h05, 8'hFE, 17'h0);
    pulse_start(32'h1, 8'd1, 17'h0);
    wait_done("t3_done", 5000);
    check("t3_err", 64'(done_err), 64'(ERR_R1));
    check("t3_writes", 64'(wr_n), 64'd0);
    check("t3_last_cs", 64'(last_cmd), 64'(SD_CS_DIS));
    check("t3_trx", 64'(sess_trx[0]), 64'd7);

    // R1 never arrives.
    do_reset(); model_clear(8'hFF, 8'hFE, 17'h0);
    pulse_start(32'h1, 8'd1, 17'h0);
    wait_done("t4_done", 5000);
    check("t4_err", 64'(done_err), 64'(ERR_R1_TO));
    check("t4_trx", 64'(sess_trx[0]), 64'd14);

    // Token never arrives.
    do_reset(); model_clear(8'h00, 8'hFF, 17'h0);
    pulse_start(32'h1, 8'd1, 17'h0);
    wait_done("t5_done", 60000);
    check("t5_err", 64'(done_err), 64'(ERR_TOKEN));
    check("t5_trx", 64'(sess_trx[0]), 64'd4103);
    check("t5_writes", 64'(wr_n), 64'd0);

    // Bad token.
    do_reset(); model_clear(8'h00, 8'hFC, 17'h0);
    pulse_start(32'h1, 8'd1, 17'h0);
    wait_done("t6_done", 5000);
    check("t6_err", 64'(done_err), 64'(ERR_TOKEN));
    check("t6_trx", 64'(sess_trx[0]), 64'd8);

    // Controller busy stuck high.
    do_reset(); model_clear(8'h00, 8'hFE, 17'h0);
    stuck = 1'b1;
    pulse_start(32'h1, 8'd1, 17'h0);
    wait_done("t7_done", 5000);
    check("t7_err", 64'(done_err), 64'(ERR_HS));

    // Controller timeout during the command frame.
    do_reset(); model_clear(8'h00, 8'hFE, 17'h0);
    to_en = 1'b1;
    pulse_start(32'h1, 8'd1, 17'h0);
    wait_done("t8_done", 5000);
    check("t8_err", 64'(done_err), 64'(ERR_HS));
    check("t8_last_cs", 64'(last_cmd), 64'(SD_CS_DIS));
    check("t8_trx", 64'(sess_trx[0]), 64'd3);

    // count=0 straight from the previous error: done next cycle, err cleared.
    @(negedge clock);
    start = 1'b1; count = 8'd0;
    @(negedge clock);
    start = 1'b0;
    check("t9_done", {busy, done, err}, {1'b0, 1'b1, ERR_OK});
    @(negedge clock);
    check("t9_done_low", {busy, done}, 64'd0);

    // Reset in the middle of DATA, then a fresh run.
    do_reset(); model_clear(8'h00, 8'hFE, 17'h00400);
    pulse_start(32'h20, 8'd1, 17'h00400);
    for (int n = 0; n < 20000 && wr_n < 100; n++) @(negedge clock);
    check("t10_mid_data", 64'(wr_n >= 100), 64'd1);
    reset_n = 1'b0;
    @(negedge clock);
    check("t10_reset_outs", {busy, done, err, sd_cmd, sd_out, sd_signal, mem_addr, mem_data, mem_we}, 64'd0);
    reset_n = 1'b1;
    model_clear(8'h00, 8'hFE, 17'h00400);
    pulse_start(32'h20, 8'd1, 17'h00400);
    wait_done("t10_done", 20000);
    check("t10_pre", {ev_cmd[0], ev_byte[0], ev_cmd[1], ev_byte[1]}, {SD_CS_DIS, 8'hFF, SD_TRX, 8'hFF});
    check("t10_err", 64'(done_err), 64'(ERR_OK));
    check("t10_writes", 64'(wr_n), 64'd512);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sd_sector_loader.md
Name: sd_sector_loader

Overview:
- Sequencer that drives the SPI SD controller's byte interface to read 512-byte sectors (CMD17, block addressing).
- Streams each data byte into the 128k tape store, so a TAP image is loaded from SD card instead of being preloaded.
- Sits between the SD controller and the tape store's write port, alongside mmap.
- Started by a one-cycle request; reports busy, done and an error code.

Parameters:
- R1_TRIES, 8: maximum poll bytes while waiting for the R1 response.
- TOKEN_TRIES, 4096: maximum poll bytes while waiting for the 0xFE data token.
- HS_TIMEOUT, 1023: clock cycles allowed per byte handshake before aborting.

Ports:
- clock  in  1  system clock (clock_cpu domain).
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; ignored while busy=1.
- lba  in  32  first sector number.
- count  in  8  number of sectors to read.
- dst  in  17  first tape-store byte address.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at completion, success or error.
- err  out  3  result code, valid from done until the next start.
- sd_cmd  out  2  0=INIT, 1=TRX byte, 2=CS enable, 3=CS disable.
- sd_out  out  8  byte to transmit.
- sd_signal  out  1  one-cycle command strobe.
- sd_din  in  8  received byte, valid when sd_busy falls.
- sd_busy  in  1  SD controller busy.
- sd_timeout  in  1  SD controller timeout flag.
- mem_addr  out  17  tape-store write address.
- mem_data  out  8  tape-store write data.
- mem_we  out  1  one-cycle write strobe.

Behaviour:
- Reset: all outputs 0 (busy, done, err, sd_cmd, sd_out, sd_signal, mem_*); FSM goes to IDLE; retry and handshake counters cleared.
  - A reset mid-transfer abandons the operation and sends no CS disable.
  - Because of that, every run issues CS disable plus one 0xFF dummy byte before asserting CS enable.
- Byte handshake (XFER):
  - Drive sd_cmd/sd_out and pulse sd_signal for 1 cycle.
  - Wait until sd_busy has been seen 1 and then 0.
  - Capture sd_din on the cycle sd_busy is seen 0.
  - If sd_timeout=1, or HS_TIMEOUT cycles pass without completion, go to FAIL with err=4.
- start in IDLE with count=0: done pulses 1 cycle later, err=0, busy never rises.
- start in IDLE with count>0: latch lba, count and dst; busy=1; clear err.
- State sequence:
  - PRE: CS disable, then TRX 0xFF.
  - CS_ON: CS enable.
  - CMD: TRX six bytes, 0x51, lba[31:24], lba[23:16], lba[15:8], lba[7:0], 0x01.
  - R1: TRX 0xFF repeatedly.
    - 0xFF: keep polling.
    - 0x00: go to TOKEN.
    - Any other value: err=1.
    - More than R1_TRIES polls: err=2.
  - TOKEN: TRX 0xFF repeatedly.
    - 0xFE: go to DATA.
    - 0xFF: keep polling.
    - Any other byte, or more than TOKEN_TRIES polls: err=3.
  - DATA: 512 TRX 0xFF.
    - Each received byte produces mem_we=1 for exactly 1 cycle with mem_addr = current address and mem_data = sd_din.
    - The address then increments modulo 2^17 (0x1FFFF wraps to 0x00000).
  - CRC: 2 TRX 0xFF; the CRC is discarded.
  - CS_OFF: CS disable.
  - NEXT: decrement count and increment lba (32-bit wrap).
    - count≠0: back to CS_ON.
    - count=0: DONE.
  - FAIL: CS disable, then DONE.
  - DONE: done=1 for 1 cycle, busy=0, return to IDLE.
- Error codes: 0 ok, 1 bad R1, 2 R1 timeout, 3 token error or timeout, 4 SD handshake timeout. err holds until the next accepted start.
- At most one sd_signal is outstanding at any time; sd_signal is never asserted while sd_busy=1.
- mem_we never asserts outside DATA.

Decomposition:
- Shared package holds:
  - SD command codes: SD_INIT, SD_TRX, SD_CS_EN, SD_CS_DIS.
  - CMD17 opcode 0x51, dummy CRC 0x01, data token 0xFE, fill byte 0xFF.
  - Error codes ERR_OK..ERR_HS.
  - SECTOR_BYTES = 512.
- One sub-module, sd_byte_xfer: the strobe/busy-edge/timeout handshake with req/ack/rx byte/timeout ports. The top module holds the sector FSM and counters.

Test Plan:
- Bus model (SD card + controller, 4-cycle busy per byte) answers R1 0x00, token 0xFE, data = i[7:0].
  - Stimulus: start with lba=0x00000010, count=1, dst=0x01000.
  - Required: command bytes 51 00 00 00 10 01; 512 writes to 0x01000..0x011FF with data i[7:0]; done with err=0; CS disabled last.
- Stimulus: count=2, dst=0x1FF00.
  - Required: second command carries lba+1; 1024 writes with addresses wrapping 0x1FFFF→0x00000; done with err=0.
- R1 = 0x05: err=1, no mem_we, CS disable issued. R1 always 0xFF: err=2 after exactly 8 polls.
- Token always 0xFF: err=3 after 4096 polls. Token 0xFC: err=3 immediately.
- sd_busy stuck at 1: err=4 after 1023 cycles. sd_timeout pulsed during CMD: err=4.
- Idle checks: start with count=0 gives done 1 cycle later, err=0. start while busy is ignored. reset_n low mid-DATA: all outputs 0 next cycle; a following start begins with CS disable + 0xFF.
